// File: rtl/sumador_secuencial_pkg.sv
// Shared definitions for the multi-cycle nibble-serial arithmetic blocks.
// Holds the controller state type, the slice width and the index-width helper.
package sumador_secuencial_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SUMANDO = 2'd1,
    HECHO   = 2'd2
  } estado_t;

  // Width of a counter that walks 0..n-1; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sumador_secuencial_adder4B.sv
// 4-bit ripple-carry adder slice: four chained full adders.
module adder4B (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       cout_o
);

  logic [4:0] c;

  assign c[0] = cin_i;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fa
    assign s_o[gi]  = a_i[gi] ^ b_i[gi] ^ c[gi];
    assign c[gi+1]  = (a_i[gi] & b_i[gi]) | (c[gi] & (a_i[gi] ^ b_i[gi]));
  end

  assign cout_o = c[4];

endmodule

// File: rtl/sumador_secuencial.sv
// Wide adder that processes one nibble per clock through a single 4-bit slice,
// chaining the carry between cycles and publishing the full result at the end.
module sumador_secuencial
  import sumador_secuencial_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inicio,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        entAcarreo,
  output logic                        ocupado,
  output logic                        listo,
  output logic [NIBBLE_W*NIBBLES-1:0] suma,
  output logic                        salAcarreo,
  output logic                        desbordamiento
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = idx_width(NIBBLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

  estado_t       estado_q, estado_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  suma_q, suma_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] a_nib [NIBBLES];
  logic [NIBBLE_W-1:0] b_nib [NIBBLES];
  logic [NIBBLE_W-1:0] a_sel, b_sel, slice_sum;
  logic                slice_cout;
  logic [W-1:0]        acc_wr;

  // Split the latched operands into nibbles and build the accumulator with
  // the current slice result dropped into position idx.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign a_nib[gi] = a_q[gi*NIBBLE_W +: NIBBLE_W];
    assign b_nib[gi] = b_q[gi*NIBBLE_W +: NIBBLE_W];
    assign acc_wr[gi*NIBBLE_W +: NIBBLE_W] =
      (idx_q == IW'(gi)) ? slice_sum : acc_q[gi*NIBBLE_W +: NIBBLE_W];
  end

  assign a_sel = a_nib[idx_q];
  assign b_sel = b_nib[idx_q];

  adder4B u_slice (
    .a_i    (a_sel),
    .b_i    (b_sel),
    .cin_i  (carry_q),
    .s_o    (slice_sum),
    .cout_o (slice_cout)
  );

  always_comb begin
    estado_d = estado_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    suma_d   = suma_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (estado_q)
      IDLE: begin
        if (inicio) begin
          a_d      = a;
          b_d      = b;
          carry_d  = entAcarreo;
          idx_d    = '0;
          estado_d = SUMANDO;
        end
      end
      SUMANDO: begin
        acc_d   = acc_wr;
        carry_d = slice_cout;
        if (idx_q == IDX_LAST) begin
          // Result registers only ever see the completed accumulator.
          idx_d    = '0;
          suma_d   = acc_wr;
          cout_d   = slice_cout;
          ovf_d    = (a_q[W-1] == b_q[W-1]) && (acc_wr[W-1] != a_q[W-1]);
          estado_d = HECHO;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      HECHO:   estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      suma_q   <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      suma_q   <= suma_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ocupado        = (estado_q != IDLE);
  assign listo          = (estado_q == HECHO);
  assign suma           = suma_q;
  assign salAcarreo     = cout_q;
  assign desbordamiento = ovf_q;

endmodule

// File: tb/tb_sumador_secuencial.sv
// Directed bench for the nibble-serial adder: hand-computed vectors, timing
// of ocupado/listo, ignored restarts, operand changes and mid-operation reset.
module tb_sumador_secuencial;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst;
  logic         inicio;
  logic [W-1:0] a, b;
  logic         entAcarreo;
  logic         ocupado, listo, salAcarreo, desbordamiento;
  logic [W-1:0] suma;

  int checks = 0;
  int errors = 0;

  // Result the DUT is expected to be holding before the current op completes.
  logic [W-1:0] prev_suma = '0;
  logic         prev_c    = 1'b0;
  logic         prev_v    = 1'b0;

  always #5 clk = ~clk;

  sumador_secuencial #(.NIBBLES(NIBBLES)) dut (
    .clk            (clk),
    .rst            (rst),
    .inicio         (inicio),
    .a              (a),
    .b              (b),
    .entAcarreo     (entAcarreo),
    .ocupado        (ocupado),
    .listo          (listo),
    .suma           (suma),
    .salAcarreo     (salAcarreo),
    .desbordamiento (desbordamiento)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one operation from the accept edge through the return to IDLE.
  // If glitch_k > 0, a second request with different operands is raised so
  // that it is sampled on edge E0+glitch_k; it must be ignored.
  task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic [W-1:0] es, input logic ec,
                        input logic ev, input int glitch_k);
    a = va; b = vb; entAcarreo = vc; inicio = 1'b1;
    tick();
    inicio = 1'b0;
    a = ~va; b = ~vb; entAcarreo = ~vc;
    chk({name, "_ocupado_E0"}, 32'(ocupado), 32'd1);
    chk({name, "_listo_E0"}, 32'(listo), 32'd0);
    for (int k = 1; k <= NIBBLES + 1; k++) begin
      if (k == glitch_k) begin
        inicio = 1'b1; a = 16'hAAAA; b = 16'h5555;
      end
      tick();
      inicio = 1'b0;
      chk($sformatf("%s_listo_E%0d", name, k), 32'(listo), 32'(k == NIBBLES));
      chk($sformatf("%s_ocupado_E%0d", name, k), 32'(ocupado), 32'(k <= NIBBLES));
      if (k < NIBBLES) begin
        chk($sformatf("%s_suma_hold_E%0d", name, k), 32'(suma), 32'(prev_suma));
      end else begin
        chk($sformatf("%s_suma_E%0d", name, k), 32'(suma), 32'(es));
        chk($sformatf("%s_cout_E%0d", name, k), 32'(salAcarreo), 32'(ec));
        chk($sformatf("%s_ovf_E%0d", name, k), 32'(desbordamiento), 32'(ev));
      end
    end
    $display("op %s a=%h b=%h cin=%0d -> suma=%h c=%0d v=%0d", name, va, vb, vc,
             suma, salAcarreo, desbordamiento);
    prev_suma = es; prev_c = ec; prev_v = ev;
  endtask

  initial begin
    rst = 1'b1; inicio = 1'b0; a = '0; b = '0; entAcarreo = 1'b0;
    tick();
    tick();
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_listo", 32'(listo), 32'd0);
    chk("rst_suma", 32'(suma), 32'd0);
    chk("rst_cout", 32'(salAcarreo), 32'd0);
    chk("rst_ovf", 32'(desbordamiento), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_ocupado", 32'(ocupado), 32'd0);

    run_op("basic",    16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
    run_op("ripple",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run_op("posovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    run_op("negovf",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
    run_op("cin",      16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
    run_op("ignored",  16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 2);

    // Request raised during HECHO must not be taken; held, it is taken from IDLE.
    a = 16'h0001; b = 16'h0001; entAcarreo = 1'b0; inicio = 1'b1;
    tick(); // E0 accepted
    inicio = 1'b0;
    for (int k = 1; k < NIBBLES; k++) tick();
    tick(); // E_NIBBLES: now in HECHO
    chk("hecho_listo", 32'(listo), 32'd1);
    chk("hecho_suma", 32'(suma), 32'h0002);
    inicio = 1'b1; a = 16'h0003; b = 16'h0004;
    tick(); // HECHO -> IDLE, request ignored
    chk("hecho_ignore_ocupado", 32'(ocupado), 32'd0);
    chk("hecho_ignore_listo", 32'(listo), 32'd0);
    prev_suma = 16'h0002;
    run_op("reaccept", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 0);

    // Reset sampled on E0+2 abandons the operation.
    a = 16'hABCD; b = 16'h1111; entAcarreo = 1'b0; inicio = 1'b1;
    tick();
    inicio = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ocupado", 32'(ocupado), 32'd0);
    chk("midrst_suma", 32'(suma), 32'd0);
    chk("midrst_cout", 32'(salAcarreo), 32'd0);
    chk("midrst_listo", 32'(listo), 32'd0);
    for (int k = 0; k < NIBBLES + 2; k++) begin
      tick();
      chk($sformatf("midrst_nolisto_%0d", k), 32'(listo), 32'd0);
    end
    $display("op midrst a=abcd b=1111 abandoned suma=%h", suma);
    prev_suma = '0;
    run_op("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sumador_secuencial.md
Name: sumador_secuencial

Overview:
- Multi-cycle wide adder. Adds two NIBBLES×4-bit operands one nibble per clock, with carry chained across cycles.
- Latches the operands on a start pulse and drives one 4-bit ripple adder slice each cycle.
- Captures that slice's sum and carry-out, then presents the full-width result with a one-cycle done pulse.
- Sits directly upstream and downstream of the 4-bit adder: it feeds the adder and consumes what the adder produces.

Parameters:
- NIBBLES, 4, number of 4-bit slices. Operand/result width W = 4*NIBBLES. Legal range 2..16.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- inicio  in  1  start request, sampled only in IDLE.
- a  in  W  operand A, sampled on the accepting edge.
- b  in  W  operand B, sampled on the accepting edge.
- entAcarreo  in  1  carry-in to nibble 0, sampled on the accepting edge.
- ocupado  out  1  high in SUMANDO and HECHO.
- listo  out  1  one-cycle done pulse, high in HECHO.
- suma  out  W  registered result.
- salAcarreo  out  1  carry-out of the most significant nibble.
- desbordamiento  out  1  two's-complement signed overflow.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). No other clock or reset.
- Reset (any state, including mid-operation):
  - state=IDLE; nibble index=0; internal carry=0; operand and accumulator registers=0.
  - suma=0, salAcarreo=0, desbordamiento=0, ocupado=0, listo=0.
  - An operation in progress is abandoned; no listo pulse is produced for it.
- FSM states IDLE, SUMANDO, HECHO (encoding is free).
- IDLE:
  - Edge with inicio=1 (the accept edge E0): latch a, b and entAcarreo into the carry register; set idx=0; go to SUMANDO.
  - inicio=0: stay in IDLE.
- SUMANDO, edge Ek for k=1..NIBBLES:
  - Slice inputs: nibble idx of the latched A and B, plus the carry register.
  - Write the slice sum into accumulator nibble idx; carry register <= slice carry-out; idx <= idx+1.
  - On edge E_NIBBLES (idx==NIBBLES-1):
    - suma <= completed accumulator (including the nibble written this edge).
    - salAcarreo <= slice carry-out.
    - desbordamiento <= (A[W-1]==B[W-1]) && (final sum bit W-1 != A[W-1]).
    - Go to HECHO.
- HECHO: listo=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- Latency: listo is high in the cycle following E_NIBBLES, i.e. NIBBLES+1 edges after the accept edge. Throughput is one operation per NIBBLES+2 cycles.
- inicio asserted in SUMANDO or HECHO is ignored (not queued). The requester must reassert it once ocupado=0.
- Operands may change after E0 without affecting the result.
- suma, salAcarreo and desbordamiento change only at E_NIBBLES or reset, and hold until the next completion. suma never shows partial nibbles.
- Arithmetic is unsigned modulo 2^W; the carry leaves through salAcarreo. Signed overflow is flagged independently of salAcarreo.
- idx width is clog2(NIBBLES) and never exceeds NIBBLES-1.

Decomposition:
- Shared package:
  - FSM state typedef (IDLE, SUMANDO, HECHO).
  - NIBBLE_W=4 constant.
  - Index-width function (clog2) used by this block and future multi-cycle arithmetic blocks.
- One sub-module: the existing 4-bit ripple adder (adder4B), instantiated once as the datapath slice and driven bit-wise from the selected nibbles.
- The FSM, index counter, operand and result registers live in sumador_secuencial itself.

Test Plan:
- NIBBLES=4, a=0x1234, b=0x4321, entAcarreo=0, one-cycle inicio -> ocupado=1 from the cycle after E0; listo high exactly in cycle E0+5; suma=0x5555, salAcarreo=0, desbordamiento=0.
- a=0xFFFF, b=0x0001, entAcarreo=0 -> suma=0x0000, salAcarreo=1, desbordamiento=0. Checks carry ripple across all four cycles.
- a=0x7FFF, b=0x0001 -> suma=0x8000, salAcarreo=0, desbordamiento=1. Then a=0x8000, b=0x8000 -> suma=0x0000, salAcarreo=1, desbordamiento=1.
- a=0x0000, b=0xFFFF, entAcarreo=1 -> suma=0x0000, salAcarreo=1. Carry-in must propagate through every nibble.
- Start 0x1111+0x2222, change a/b and pulse inicio again at E0+2 -> second request ignored; result 0x3333; listo pulses once. After listo, a new inicio is accepted only once back in IDLE.
- Start an operation, assert rst at E0+2 -> next cycle: ocupado=0, suma=0, salAcarreo=0; no listo pulse. A following start of 0x0F0F+0x00F1 -> suma=0x1000.
